// File: rtl/aes128_decrypt_iter.sv
// Round-iterative AES-128 inverse cipher: on-chip key expansion with a one-key cache,
// then one inverse round per clock, valid/ready handshakes on both sides.
module aes128_decrypt_iter #(
    parameter int KEY_REUSE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, KEYEXP, ROUNDS, DONE} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [127:0] state_reg, ct_reg, plaintext_reg;
    logic         out_valid_reg, cache_valid_reg;
    logic [127:0] rk_reg [0:10];

    logic [127:0] round_key, prev_key, next_key, isb, added, mixed;
    logic [31:0]  sub_word, temp_word;
    logic [7:0]   rcon;
    logic         key_hit;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; zero naturally maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc, sq;
        acc = 8'h01;
        sq  = a;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    assign round_key = rk_reg[cnt_reg];
    assign prev_key  = rk_reg[cnt_reg - 4'd1];
    assign key_hit   = (KEY_REUSE != 0) && cache_valid_reg && (key == rk_reg[0]);

    always_comb begin
        rcon = 8'h00;
        case (cnt_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    genvar gi;
    generate
        // SubWord(RotWord(w3)): output byte gi comes from w3 byte (gi+1)%4
        for (gi = 0; gi < 4; gi++) begin : g_subword
            localparam int SRC = (gi + 1) % 4;
            assign sub_word[31-8*gi -: 8] = sbox(prev_key[31-8*SRC -: 8]);
        end
        // InvShiftRows folded into the InvSubBytes input selection
        for (gi = 0; gi < 16; gi++) begin : g_isb
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign isb[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mixed[127-32*gi -: 32] = inv_mix_col(added[127-32*gi -: 32]);
        end
    endgenerate

    assign temp_word = sub_word ^ {rcon, 24'h000000};
    assign next_key[127:96] = prev_key[127:96] ^ temp_word;
    assign next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
    assign next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
    assign next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
    assign added = isb ^ round_key;

    always_comb begin
        fsm_next = fsm_reg;
        cnt_next = cnt_reg;
        case (fsm_reg)
            IDLE: begin
                if (in_valid) begin
                    fsm_next = key_hit ? ROUNDS : KEYEXP;
                    cnt_next = key_hit ? 4'd9 : 4'd1;
                end
            end
            KEYEXP: begin
                if (cnt_reg == 4'd10) begin
                    fsm_next = ROUNDS;
                    cnt_next = 4'd9;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ROUNDS: begin
                if (cnt_reg == 4'd0) fsm_next = DONE;
                else                 cnt_next = cnt_reg - 4'd1;
            end
            DONE:    if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg         <= IDLE;
            cnt_reg         <= 4'd0;
            state_reg       <= '0;
            ct_reg          <= '0;
            plaintext_reg   <= '0;
            out_valid_reg   <= 1'b0;
            cache_valid_reg <= 1'b0;
        end else begin
            fsm_reg <= fsm_next;
            cnt_reg <= cnt_next;
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        ct_reg <= ciphertext;
                        if (key_hit) state_reg <= ciphertext ^ rk_reg[10];
                        else         cache_valid_reg <= 1'b0;
                    end
                end
                KEYEXP: begin
                    if (cnt_reg == 4'd10) begin
                        state_reg       <= ct_reg ^ next_key;
                        cache_valid_reg <= 1'b1;
                    end
                end
                ROUNDS: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= added;
                        plaintext_reg <= added;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= mixed;
                    end
                end
                DONE:    if (out_ready) out_valid_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    // Key storage carries no reset; the cache flag alone decides whether it is trusted
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fsm_reg == IDLE && in_valid) rk_reg[0] <= key;
            else if (fsm_reg == KEYEXP)      rk_reg[cnt_reg] <= next_key;
        end
    end

    assign in_ready  = (fsm_reg == IDLE);
    assign busy      = (fsm_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign plaintext = plaintext_reg;
endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Sequential, round-iterative AES-128 inverse cipher with valid/ready handshakes on input and output.
- It is the receive-side counterpart to the combinational AES-128 encrypt path: ciphertext produced upstream is streamed in, one block at a time, and recovered as plaintext.
- Round keys are expanded on-chip once per key and cached. Each inverse round then takes one clock, which trades latency for a much smaller area than the fully unrolled decipher.

Parameters:
- KEY_REUSE, 1: when 1, key expansion is skipped if the new key equals the cached key. When 0, every block re-expands its key.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext/key presented.
- in_ready  output  1  block can accept; high only in IDLE.
- ciphertext  input  128  block to decrypt; byte 0 is in [127:120].
- key  input  128  AES-128 cipher key, same byte order.
- out_valid  output  1  plaintext available.
- out_ready  input  1  downstream accepts plaintext.
- plaintext  output  128  decrypted block.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - in_ready=1 after the first post-reset edge (state=IDLE).
  - out_valid=0, busy=0, plaintext=0.
  - Cached-key-valid flag=0, round counter=0.
- Reset mid-operation abandons the block and clears the key cache. Nothing is emitted. The block is back in IDLE on the next edge.
- State machine: IDLE, KEYEXP, ROUNDS, DONE.
- IDLE:
  - The input handshake fires on an edge where in_valid && in_ready. That edge registers ciphertext and key and stores key as rk[0].
  - If KEY_REUSE=1, the cache flag is set, and key==cached rk[0], go to ROUNDS. The same edge loads state <= ciphertext ^ rk[10].
  - Otherwise go to KEYEXP with counter i=1.
- KEYEXP:
  - Each edge writes rk[i] <= next_key(rk[i-1], Rcon[i]).
  - Key schedule: RotWord, SubWord, Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - At i=10 the edge also loads state <= ct_reg ^ next_key, sets the cache flag, and moves to ROUNDS with r=9.
  - Exactly 10 edges are spent in KEYEXP.
- ROUNDS:
  - For r=9..1, one edge each: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - After r=1, one final edge: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]. The same edge sets out_valid=1 and moves to DONE.
- Latency, counted in rising edges after the input-handshake edge until out_valid is visible:
  - 20 with key expansion (10 KEYEXP + 10 round edges).
  - 10 on a cache hit. The 11-cycle total includes the handshake edge that performs the initial AddRoundKey.
- DONE:
  - plaintext is held stable and out_valid is held high until an edge with out_ready=1.
  - That edge clears out_valid and returns to IDLE. in_ready rises on the following cycle; there is no same-edge output+input overlap.
  - out_ready while out_valid=0 is ignored.
- in_valid while busy is ignored and no data is captured. The upstream must hold its data until in_ready.
- S-box and inverse S-box are computed arithmetically, with no lookup tables:
  - Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, computed as x^254, with 0 mapping to 0.
  - The FIPS-197 forward affine transform (constant 63) or its inverse (constant 05) is applied as appropriate.
- InvMixColumns uses coefficients 0e, 0b, 0d, 09.
- Round-key storage: 11x128-bit registers. The cache compares the full 128-bit key.

Test Plan:
- FIPS-197 C.1 vector: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f.
  - Required: plaintext 00112233445566778899aabbccddeeff with out_valid exactly 20 edges after the handshake.
  - busy stays high throughout; in_ready stays low.
- Cache hit: repeat the same key with the same ciphertext, out_ready=1.
  - KEY_REUSE=1: same plaintext after 10 edges.
  - KEY_REUSE=0 build: 20 edges.
- Key change: FIPS-197 B vector, ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: plaintext 3243f6a8885a308d313198a2e0370734 after 20 edges (cache miss).
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: plaintext and out_valid stable; a second in_valid pulse during this time is not captured.
  - After out_ready=1: out_valid drops and in_ready=1 one cycle later.
- Reset mid-operation: assert reset during KEYEXP (i=4), then resubmit C.1 with the same key.
  - Required: no out_valid; outputs at reset values; the resubmitted block takes 20 edges, confirming the cache was cleared.
- Idle robustness: out_ready toggling with no block in flight produces no out_valid; in_valid=0 keeps the block in IDLE indefinitely.
